// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-beat stb/ack memory bus between the fetch port and the data port.
// Optional watchdog: define BUS_TIMEOUT_EN to abort stalled transactions and report them on bus_err.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_stb,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_sel,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
`ifdef BUS_TIMEOUT_EN
  output logic                bus_err,
`endif
  output logic                stallreq_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

  state_t state_reg, state_next;
  logic   last_d_reg;
  logic   i_pend, d_pend;
  logic   grant_i, grant_d, finish_i, finish_d;
  logic   timeout_hit;

  // A port whose ack is showing this cycle is already served; the requester drops req next cycle.
  assign i_pend = i_req & ~i_ack & ~flush;
  assign d_pend = d_req & ~d_ack;

  assign stallreq_o = (i_req & ~i_ack) | (d_req & ~d_ack) | (state_reg == DRAIN);

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CNT_W-1:0] cnt_reg;

  assign timeout_hit = (state_reg != IDLE) && !m_ack && (cnt_reg >= CNT_W'(TIMEOUT - 1));

  // Held at zero while idle, so every grant starts the watchdog from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      cnt_reg <= '0;
    end else if (!timeout_hit) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    finish_i   = 1'b0;
    finish_d   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Data wins a tie unless it was served last, which keeps fetch from starving.
        if (d_pend && !(i_pend && last_d_reg)) begin
          state_next = BUSY_D;
          grant_d    = 1'b1;
        end else if (i_pend) begin
          state_next = BUSY_I;
          grant_i    = 1'b1;
        end
      end
      BUSY_I: begin
        if (m_ack || timeout_hit) begin
          state_next = IDLE;
          finish_i   = ~flush;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      BUSY_D: begin
        if (m_ack || timeout_hit) begin
          state_next = IDLE;
          finish_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (m_ack || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_stb      <= 1'b0;
      m_we       <= 1'b0;
      m_sel      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      i_ack      <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      last_d_reg <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
    end else begin
      i_ack <= finish_i;
      d_ack <= finish_d;
      if (grant_d) begin
        m_stb   <= 1'b1;
        m_we    <= d_we;
        m_sel   <= d_sel;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_stb   <= 1'b1;
        m_we    <= 1'b0;
        m_sel   <= '1;
        m_addr  <= i_addr;
        m_wdata <= '0;
      end else if (state_next == IDLE) begin
        m_stb   <= 1'b0;
      end
      // Without m_ack a finish can only be a watchdog abort, which returns zero data.
      if (finish_i) begin
        i_rdata    <= m_ack ? m_rdata : '0;
        last_d_reg <= 1'b0;
      end
      if (finish_d) begin
        d_rdata    <= (m_ack && !m_we) ? m_rdata : '0;
        last_d_reg <= 1'b1;
      end
`ifdef BUS_TIMEOUT_EN
      bus_err <= (finish_i | finish_d) & ~m_ack;
`endif
    end
  end

endmodule
